// File: rtl/uart_reg_sched.sv
// Register-bus master for a 16550-style UART: writes the line settings after reset, then
// time-shares the bus between LSR polling, RBR draining and THR filling.
module uart_reg_sched #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter logic [7:0]  LCR_VAL     = 8'h03
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    output logic       reg_awvalid,
    input  logic       reg_awready,
    output logic [2:0] reg_awaddr,
    output logic       reg_wvalid,
    input  logic       reg_wready,
    output logic [7:0] reg_wdata,
    input  logic       reg_bvalid,
    output logic       reg_bready,
    input  logic [1:0] reg_bresp,
    output logic       reg_arvalid,
    input  logic       reg_arready,
    output logic [2:0] reg_araddr,
    input  logic       reg_rvalid,
    output logic       reg_rready,
    input  logic [7:0] reg_rdata,
    input  logic [1:0] reg_rresp,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       cfg_done,
    output logic       bus_err
);

    localparam logic [15:0] DIVISOR = 16'((CLK_FREQ_HZ + 8 * BAUD) / (16 * BAUD));
    localparam logic [2:0]  A_DATA  = 3'd0;   // RBR / THR / DLL
    localparam logic [2:0]  A_DLM   = 3'd1;
    localparam logic [2:0]  A_LCR   = 3'd3;
    localparam logic [2:0]  A_LSR   = 3'd5;

    typedef enum logic [2:0] {
        CFG_LCR1, CFG_DLL, CFG_DLM, CFG_LCR2, POLL, DECIDE, RD_RBR, WR_THR
    } state_t;
    typedef enum logic { PH_ISSUE, PH_WAIT } phase_t;

    state_t     r_state;
    phase_t     r_phase;
    logic       r_awvalid, r_wvalid, r_arvalid;
    logic [2:0] r_awaddr, r_araddr;
    logic [7:0] r_wdata;
    logic       r_cfg_done, r_bus_err;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [7:0] r_tx_byte;
    logic       r_tx_full;
    logic       r_prio;
    logic       r_lsr_dr, r_lsr_thre;

    logic [2:0] w_cfg_addr;
    logic [7:0] w_cfg_data;
    state_t     w_cfg_next;
    logic       w_rx_ok, w_tx_ok, w_serve_rx, w_tx_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_cfg_addr = A_LCR;
        w_cfg_data = LCR_VAL | 8'h80;
        w_cfg_next = CFG_DLL;
        case (r_state)
            CFG_DLL:  begin w_cfg_addr = A_DATA; w_cfg_data = DIVISOR[7:0];     w_cfg_next = CFG_DLM;  end
            CFG_DLM:  begin w_cfg_addr = A_DLM;  w_cfg_data = DIVISOR[15:8];    w_cfg_next = CFG_LCR2; end
            CFG_LCR2: begin w_cfg_addr = A_LCR;  w_cfg_data = LCR_VAL & 8'h7F;  w_cfg_next = POLL;     end
            default:  ;
        endcase
    end

    assign w_rx_ok    = r_lsr_dr & ~r_rx_valid;
    assign w_tx_ok    = r_lsr_thre & r_tx_full;
    assign w_serve_rx = w_rx_ok & (~w_tx_ok | ~r_prio);
    assign w_tx_ready = r_cfg_done & ~r_tx_full;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= CFG_LCR1;
            r_phase    <= PH_ISSUE;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_awaddr   <= '0;
            r_araddr   <= '0;
            r_wdata    <= '0;
            r_cfg_done <= 1'b0;
            r_bus_err  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_byte  <= '0;
            r_tx_full  <= 1'b0;
            r_prio     <= 1'b0;
            r_lsr_dr   <= 1'b0;
            r_lsr_thre <= 1'b0;
        end else begin
            if (r_awvalid && reg_awready) r_awvalid <= 1'b0;
            if (r_wvalid && reg_wready)   r_wvalid  <= 1'b0;
            if (r_arvalid && reg_arready) r_arvalid <= 1'b0;
            if ((reg_bvalid && reg_bresp != 2'b00) || (reg_rvalid && reg_rresp != 2'b00))
                r_bus_err <= 1'b1;
            if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
            if (tx_valid && w_tx_ready) begin
                r_tx_full <= 1'b1;
                r_tx_byte <= tx_data;
            end

            case (r_state)
                CFG_LCR1, CFG_DLL, CFG_DLM, CFG_LCR2: begin
                    if (r_phase == PH_ISSUE) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= w_cfg_addr;
                        r_wdata   <= w_cfg_data;
                        r_phase   <= PH_WAIT;
                    end else if (reg_bvalid) begin
                        r_state <= w_cfg_next;
                        r_phase <= PH_ISSUE;
                        if (r_state == CFG_LCR2) r_cfg_done <= 1'b1;
                    end
                end
                POLL: begin
                    if (r_phase == PH_ISSUE) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= A_LSR;
                        r_phase   <= PH_WAIT;
                    end else if (reg_rvalid) begin
                        // A failed LSR read reports nothing pending.
                        r_lsr_dr   <= (reg_rresp == 2'b00) & reg_rdata[0];
                        r_lsr_thre <= (reg_rresp == 2'b00) & reg_rdata[5];
                        r_state    <= DECIDE;
                    end
                end
                DECIDE: begin
                    // Issues the chosen transaction directly so an idle poll loses no cycle.
                    r_phase <= PH_WAIT;
                    if (w_rx_ok && w_tx_ok) r_prio <= ~r_prio;
                    if (w_serve_rx) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= A_DATA;
                        r_state   <= RD_RBR;
                    end else if (w_tx_ok) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= A_DATA;
                        r_wdata   <= r_tx_byte;
                        r_state   <= WR_THR;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= A_LSR;
                        r_state   <= POLL;
                    end
                end
                RD_RBR: begin
                    if (reg_rvalid) begin
                        if (reg_rresp == 2'b00) begin
                            r_rx_data  <= reg_rdata;
                            r_rx_valid <= 1'b1;
                        end
                        r_state <= POLL;
                        r_phase <= PH_ISSUE;
                    end
                end
                WR_THR: begin
                    if (reg_bvalid) begin
                        r_tx_full <= 1'b0;
                        r_state   <= POLL;
                        r_phase   <= PH_ISSUE;
                    end
                end
                default: begin
                    r_state <= POLL;
                    r_phase <= PH_ISSUE;
                end
            endcase
        end
    end

    assign reg_awvalid = r_awvalid;
    assign reg_awaddr  = r_awaddr;
    assign reg_wvalid  = r_wvalid;
    assign reg_wdata   = r_wdata;
    assign reg_bready  = 1'b1;
    assign reg_arvalid = r_arvalid;
    assign reg_araddr  = r_araddr;
    assign reg_rready  = 1'b1;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = w_tx_ready;
    assign cfg_done    = r_cfg_done;
    assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_uart_reg_sched.sv
// Bench for uart_reg_sched: a small UART register-file model (RX FIFO, always-empty THR)
// answers the bus; directed vectors and hand-written sequences check the scheduling.
module tb_uart_reg_sched;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       reg_awvalid, reg_wvalid, reg_arvalid, reg_bready, reg_rready;
    logic       reg_awready = 1'b1, reg_wready = 1'b1, reg_arready;
    logic [2:0] reg_awaddr, reg_araddr;
    logic [7:0] reg_wdata;
    logic       reg_bvalid = 1'b0, reg_rvalid = 1'b0;
    logic [1:0] reg_bresp = 2'b00, reg_rresp = 2'b00;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_ready, cfg_done, bus_err;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    logic ar_ready = 1'b1;
    logic hold     = 1'b1;
    logic rbr_err  = 1'b0;
    assign reg_arready = ar_ready;

    always #5 sys_clk = ~sys_clk;

    uart_reg_sched dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .reg_awvalid(reg_awvalid), .reg_awready(reg_awready), .reg_awaddr(reg_awaddr),
        .reg_wvalid(reg_wvalid), .reg_wready(reg_wready), .reg_wdata(reg_wdata),
        .reg_bvalid(reg_bvalid), .reg_bready(reg_bready), .reg_bresp(reg_bresp),
        .reg_arvalid(reg_arvalid), .reg_arready(reg_arready), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rready(reg_rready), .reg_rdata(reg_rdata),
        .reg_rresp(reg_rresp),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cfg_done(cfg_done), .bus_err(bus_err)
    );

    logic [10:0] wlog[$];
    logic [2:0]  rlog[$];
    logic [7:0]  ev[$];
    logic [7:0]  rx_fifo[$];
    logic [7:0]  rx_got[$];
    logic [7:0]  thr_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: write response one cycle after both AW and W are taken, read data one cycle after AR.
    logic       aw_got = 1'b0, w_got = 1'b0, n_aw_got, n_w_got;
    logic [2:0] aw_a = 3'd0, n_aw_a;
    logic [7:0] w_d = 8'h00, n_w_d;

    always_comb begin
        n_aw_got = aw_got | (reg_awvalid & reg_awready);
        n_w_got  = w_got | (reg_wvalid & reg_wready);
        n_aw_a   = (reg_awvalid && reg_awready) ? reg_awaddr : aw_a;
        n_w_d    = (reg_wvalid && reg_wready) ? reg_wdata : w_d;
    end

    always @(posedge sys_clk) begin
        reg_bvalid <= 1'b0;
        reg_rvalid <= 1'b0;
        if (sys_rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (n_aw_got && n_w_got) begin
                reg_bvalid <= 1'b1;
                reg_bresp  <= 2'b00;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                wlog.push_back({n_aw_a, n_w_d});
                if (n_aw_a == 3'd0 && cfg_done) begin
                    thr_log.push_back(n_w_d);
                    ev.push_back("T");
                end
            end else begin
                aw_got <= n_aw_got;
                w_got  <= n_w_got;
                aw_a   <= n_aw_a;
                w_d    <= n_w_d;
            end
            if (reg_arvalid && reg_arready) begin
                reg_rvalid <= 1'b1;
                rlog.push_back(reg_araddr);
                if (reg_araddr == 3'd5) begin
                    reg_rresp <= 2'b00;
                    reg_rdata <= hold ? 8'h00 : {2'b00, 1'b1, 4'b0000, (rx_fifo.size() != 0)};
                end else begin
                    reg_rresp <= rbr_err ? 2'd2 : 2'd0;
                    reg_rdata <= (rx_fifo.size() != 0) ? rx_fifo.pop_front() : 8'h00;
                    ev.push_back("R");
                end
            end
        end
    end

    always @(posedge sys_clk)
        if (!sys_rst && rx_valid && rx_ready) rx_got.push_back(rx_data);

    task automatic wait_ev(input int n, input int budget);
        int k = 0;
        while (ev.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
    endtask

    task automatic wait_cfg(input int budget);
        int k = 0;
        while (!cfg_done && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check("cfg_done_reached", cfg_done, 1'b1);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        @(negedge sys_clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    task automatic quiesce();
        hold = 1'b1;
        repeat (6) @(negedge sys_clk);
        ev.delete();
        rlog.delete();
        thr_log.delete();
        rx_got.delete();
    endtask

    typedef struct {
        logic        rx_push;
        logic [7:0]  rx_byte;
        logic        tx_push;
        logic [7:0]  tx_byte;
        int          exp_n;
        logic [15:0] exp_ev;
    } vec_t;

    vec_t vecs[4];
    logic [10:0] cfg_exp[4];
    logic [7:0]  alt_ev[6];

    initial begin
        int idx;
        int polls;
        int n_r;
        logic seen_rx;

        cfg_exp[0] = {3'd3, 8'h83};
        cfg_exp[1] = {3'd0, 8'h1B};
        cfg_exp[2] = {3'd1, 8'h00};
        cfg_exp[3] = {3'd3, 8'h03};
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1, {"R", 8'h00}};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1, {"T", 8'h00}};
        vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 2, "RT"};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 0, 16'h0000};
        alt_ev  = '{"T", "R", "T", "R", "T", "R"};

        // Reset state, then the first write address must appear one edge after release.
        repeat (3) @(negedge sys_clk);
        check("rst_awvalid", reg_awvalid, 1'b0);
        check("rst_wvalid", reg_wvalid, 1'b0);
        check("rst_arvalid", reg_arvalid, 1'b0);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_awaddr", reg_awaddr, 3'd0);
        check("rst_wdata", reg_wdata, 8'h00);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("first_awvalid", reg_awvalid, 1'b1);
        check("first_wvalid", reg_wvalid, 1'b1);
        check("first_awaddr", reg_awaddr, 3'd3);
        check("first_wdata", reg_wdata, 8'h83);

        wait_cfg(200);
        check("cfg_no_reads", rlog.size(), 0);
        check("cfg_write_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) check("cfg_write", wlog[i], cfg_exp[i]);
        check("cfg_tx_ready", tx_ready, 1'b1);

        for (int v = 0; v < 4; v++) begin
            quiesce();
            if (vecs[v].rx_push) rx_fifo.push_back(vecs[v].rx_byte);
            if (vecs[v].tx_push) push_tx(vecs[v].tx_byte);
            @(negedge sys_clk);
            hold = 1'b0;
            wait_ev(vecs[v].exp_n, 300);
            repeat (30) @(negedge sys_clk);
            check("vec_ev_count", ev.size(), vecs[v].exp_n);
            for (int i = 0; i < vecs[v].exp_n; i++)
                check("vec_ev_order", ev[i], vecs[v].exp_ev[15-8*i -: 8]);
            check("vec_rx_count", rx_got.size(), vecs[v].rx_push);
            if (vecs[v].rx_push) begin
                check("vec_rx_data", rx_got[0], vecs[v].rx_byte);
                idx = -1;
                foreach (rlog[i]) if (rlog[i] == 3'd0) idx = i;
                check("vec_rbr_read_seen", idx >= 0, 1'b1);
                check("vec_ar_after_rbr", rlog[idx+1], 3'd5);
            end
            check("vec_thr_count", thr_log.size(), vecs[v].tx_push);
            if (vecs[v].tx_push) check("vec_thr_data", thr_log[0], vecs[v].tx_byte);
            check("vec_tx_ready", tx_ready, 1'b1);
            check("vec_rx_valid", rx_valid, 1'b0);
        end

        // RX and TX both pending on every poll: service must alternate, TX first after the last toggle.
        quiesce();
        rx_fifo.push_back(8'hB0);
        rx_fifo.push_back(8'hB1);
        rx_fifo.push_back(8'hB2);
        push_tx(8'hC0);
        @(negedge sys_clk);
        hold = 1'b0;
        push_tx(8'hC1);
        push_tx(8'hC2);
        wait_ev(6, 800);
        repeat (30) @(negedge sys_clk);
        check("alt_ev_count", ev.size(), 6);
        for (int i = 0; i < 6; i++) check("alt_ev_order", ev[i], alt_ev[i]);
        check("alt_thr_count", thr_log.size(), 3);
        for (int i = 0; i < 3; i++) check("alt_thr_data", thr_log[i], 8'hC0 + 8'(i));
        check("alt_rx_count", rx_got.size(), 3);
        for (int i = 0; i < 3; i++) check("alt_rx_data", rx_got[i], 8'hB0 + 8'(i));

        // Consumer stalls: one RBR read, then only LSR polls until it accepts.
        rx_ready = 1'b0;
        quiesce();
        rx_fifo.push_back(8'hD0);
        rx_fifo.push_back(8'hD1);
        @(negedge sys_clk);
        hold = 1'b0;
        repeat (150) @(negedge sys_clk);
        n_r = 0;
        polls = 0;
        foreach (rlog[i]) begin
            if (rlog[i] == 3'd0) n_r++;
            else if (n_r > 0) polls++;
        end
        check("bp_rbr_reads", n_r, 1);
        check("bp_polls_continue", polls >= 5, 1'b1);
        check("bp_rx_valid_held", rx_valid, 1'b1);
        check("bp_rx_data_held", rx_data, 8'hD0);
        check("bp_fifo_kept", rx_fifo.size(), 1);
        @(negedge sys_clk);
        rx_ready = 1'b1;
        wait_ev(2, 300);
        repeat (30) @(negedge sys_clk);
        check("bp_rx_count", rx_got.size(), 2);
        check("bp_rx_first", rx_got[0], 8'hD0);
        check("bp_rx_second", rx_got[1], 8'hD1);

        // RBR read answered with an error: byte discarded, sticky error flag.
        check("err_pre_bus_err", bus_err, 1'b0);
        rbr_err = 1'b1;
        quiesce();
        rx_fifo.push_back(8'hE7);
        @(negedge sys_clk);
        hold = 1'b0;
        seen_rx = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge sys_clk);
            if (rx_valid) seen_rx = 1'b1;
        end
        check("err_rbr_read", ev.size(), 1);
        check("err_bus_err", bus_err, 1'b1);
        check("err_rx_valid_never", seen_rx, 1'b0);
        check("err_rx_count", rx_got.size(), 0);
        rbr_err = 1'b0;

        // Reset while an AR is stalled: valids drop on the next edge, sequence restarts cleanly.
        @(negedge sys_clk);
        ar_ready = 1'b0;
        for (int k = 0; k < 50 && !reg_arvalid; k++) @(negedge sys_clk);
        check("mid_ar_pending", reg_arvalid, 1'b1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("mid_rst_arvalid", reg_arvalid, 1'b0);
        check("mid_rst_awvalid", reg_awvalid, 1'b0);
        check("mid_rst_cfg_done", cfg_done, 1'b0);
        check("mid_rst_bus_err", bus_err, 1'b0);
        check("mid_rst_tx_ready", tx_ready, 1'b0);
        ar_ready = 1'b1;
        repeat (3) @(negedge sys_clk);
        wlog.delete();
        sys_rst = 1'b0;
        wait_cfg(200);
        check("recfg_write_count", wlog.size(), 4);
        check("recfg_first", wlog[0], cfg_exp[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
